// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One right shift plus per-digit correction per clock; start/busy/done handshake.
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      binary
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // True when any 4-bit digit of the operand is outside 0..9.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Reverse-dabble correction: a digit that is >= 8 after the shift loses 3.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd8) ? (v[4*i +: 4] - 4'd3) : v[4*i +: 4];
    end
    return r;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [BCD_W-1:0]   bcd_r, bcd_nxt_s, shift_bcd_s;
  logic [BIN_W-1:0]   bin_r, bin_nxt_s, shift_bin_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               err_r, err_nxt_s;
  logic [BIN_W-1:0]   binary_r, binary_nxt_s;

  // {bcd,bin} shifted right by one with zero entering at the top, then corrected.
  assign shift_bcd_s = correct_digits({1'b0, bcd_r[BCD_W-1:1]});
  assign shift_bin_s = {bcd_r[0], bin_r[BIN_W-1:1]};

  // Next-state and next-output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_nxt_s  = state_r;
    bcd_nxt_s    = bcd_r;
    bin_nxt_s    = bin_r;
    cnt_nxt_s    = cnt_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = 1'b0;
    err_nxt_s    = err_r;
    binary_nxt_s = binary_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (has_bad_digit(bcd_in)) begin
            done_nxt_s   = 1'b1;
            err_nxt_s    = 1'b1;
            binary_nxt_s = {BIN_W{1'b0}};
          end else begin
            bcd_nxt_s   = bcd_in;
            bin_nxt_s   = {BIN_W{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            err_nxt_s   = 1'b0;
            busy_nxt_s  = 1'b1;
            state_nxt_s = SHIFT;
          end
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      SHIFT: begin
        bcd_nxt_s = shift_bcd_s;
        bin_nxt_s = shift_bin_s;
        cnt_nxt_s = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_CNT) begin
          binary_nxt_s = shift_bin_s;
          done_nxt_s   = 1'b1;
          busy_nxt_s   = 1'b0;
          state_nxt_s  = IDLE;
        end else begin
          busy_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered-output flops; reset aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      bcd_r    <= {BCD_W{1'b0}};
      bin_r    <= {BIN_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      binary_r <= {BIN_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      bcd_r    <= bcd_nxt_s;
      bin_r    <= bin_nxt_s;
      cnt_r    <= cnt_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      err_r    <= err_nxt_s;
      binary_r <= binary_nxt_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;
  assign binary = binary_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases plus random operands
// checked against an arithmetic decimal-value reference model.
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [13:0] binary;

  int total = 0;
  int bad   = 0;

  bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .binary (binary)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: operand is legal when every digit is 0..9; value is sum of d*10^i.
  function automatic bit ref_valid(input logic [15:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (int'(b[4*i +: 4]) > 9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int ref_value(input logic [15:0] b);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      v = v + int'(b[4*i +: 4]) * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present an operand for one accepting edge, then scramble bcd_in.
  task automatic start_conv(input logic [15:0] b);
    start  = 1'b1;
    bcd_in = b;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'($urandom);
  endtask

  // Called in the cycle after the accepting edge; waits for done and checks result.
  task automatic check_result(input string tag, input logic [15:0] b, input int pulse_at);
    int lat;
    int busy_n;
    int exp_lat;
    bit ok;
    ok      = ref_valid(b);
    exp_lat = ok ? 14 : 0;
    lat     = 0;
    busy_n  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      if (lat == pulse_at) begin
        start  = 1'b1;
        bcd_in = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_n, exp_lat);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), ok ? 0 : 1);
    chk({tag, "_binary"}, int'(binary), ok ? ref_value(b) : 0);
  endtask

  initial begin
    logic [15:0] b;
    int          n;
    int          gap;
    int          extra;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_binary", int'(binary), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Largest legal operand.
    start_conv(16'h9999);
    check_result("max9999", 16'h9999, -1);
    @(negedge clk);
    chk("max9999_done_clears", int'(done), 0);

    // Back-to-back: second start in the cycle done is high.
    start_conv(16'h0000);
    check_result("zero", 16'h0000, -1);
    start_conv(16'h1234);
    chk("b2b_done_clears", int'(done), 0);
    check_result("b2b1234", 16'h1234, -1);
    @(negedge clk);

    // Invalid digit, then a legal operand clears err at the accept.
    start_conv(16'h12A4);
    check_result("bad12A4", 16'h12A4, -1);
    @(negedge clk);
    chk("bad_done_clears", int'(done), 0);
    chk("bad_err_held", int'(err), 1);
    start_conv(16'h0042);
    chk("err_clear_at_accept", int'(err), 0);
    check_result("v0042", 16'h0042, -1);
    @(negedge clk);

    // Start re-pulsed mid-conversion is ignored.
    start_conv(16'h0500);
    check_result("ignored_start", 16'h0500, 5);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("ignored_no_extra_done", extra, 0);

    // Asynchronous reset mid-conversion.
    start_conv(16'h8765);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_err", int'(err), 0);
    chk("async_rst_binary", int'(binary), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("aborted_no_done", extra, 0);
    start_conv(16'h0010);
    check_result("after_reset", 16'h0010, -1);
    @(negedge clk);

    // Start held high: one conversion per 15 cycles.
    start  = 1'b1;
    bcd_in = 16'h0321;
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_first_latency", n, 14);
    chk("hold_first_binary", int'(binary), 321);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 40);
    chk("hold_period", n, 15);
    chk("hold_second_binary", int'(binary), 321);
    start = 1'b0;
    @(negedge clk);
    chk("hold_release_busy", int'(busy), 0);
    chk("hold_release_done", int'(done), 0);

    // Random operands, mostly legal, with random gaps including back-to-back.
    for (int k = 0; k < 30; k++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 9) == 0) b[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           b[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      start_conv(b);
      check_result($sformatf("rnd%0d_%04h", k, b), b, -1);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_done_low", k), int'(done), 0);
        chk($sformatf("rnd%0d_err_held", k), int'(err), ref_valid(b) ? 0 : 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential packed-BCD to binary converter for the calculator datapath. It is the inverse of the binary-to-BCD display path.
- Takes a 4-digit BCD operand from keypad/digit entry and produces the 14-bit binary value used by the arithmetic unit.
- Uses reverse double-dabble: one shift-right plus digit correction per clock, with a start/busy/done handshake and invalid-digit detection.

Parameters:
- DIGITS, 4, number of BCD digits in the input.
- BIN_W, 14, output width and number of shift iterations. Must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 = bits [3:0]; sampled on the accepting edge.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse, result/err valid.
- err  output  1  last request had a digit >9; held until the next accepted start.
- binary  output  BIN_W  conversion result; held until the next completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, err=0, binary=0.
  - Internal shift registers and iteration counter cleared.
  - Reset mid-conversion aborts it with no done pulse.
- States: IDLE, SHIFT.
- IDLE with start=1, edge E0:
  - If any digit of bcd_in >9: stay IDLE, done=1, err=1, binary=0. No shift phase.
  - Else: load bcd_reg=bcd_in, bin_reg=0, cnt=0, err=0, busy=1, go to SHIFT.
- SHIFT, each edge:
  - {bcd_reg,bin_reg} shifted right 1, zero into the MSB.
  - Then every 4-bit digit of bcd_reg that is >=8 has 3 subtracted. Digits are corrected independently, same cycle, after the shift.
  - cnt increments.
- Completion: at edge E_BIN_W (E14 by default), after the last shift:
  - binary takes the shifted bin_reg value.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: start accepted at E0, done high in the cycle after E14. Valid conversion = 14 clocks; error = 1 clock.
- done is cleared on the following edge unless a new error-path request completes on that same edge.
- Back-to-back: the earliest next start accepted is the edge after done rises. Start asserted during SHIFT is ignored, not queued.
- start held high continuously yields repeated conversions, one per BIN_W+1 cycles.
- bcd_in changes during SHIFT have no effect.
- Widths:
  - bcd_reg is 4*DIGITS bits and bin_reg is BIN_W bits.
  - No overflow is possible for legal input, since the maximum 9999 fits in 0x270F.
  - Digit subtract never underflows, because a corrected digit is >=8.

Test Plan:
- bcd_in=16'h9999, start pulse -> busy high 14 cycles; done pulse with binary=14'd9999 (0x270F), err=0.
- bcd_in=16'h0000 then 16'h1234 back-to-back (second start on the cycle after done) -> binary=0, then binary=1234 (0x04D2); each done exactly 14 cycles after its accept.
- bcd_in=16'h12A4 -> done on the cycle after the accept, err=1, binary=0, busy never high. Then 16'h0042 -> err clears at accept, binary=42.
- start re-pulsed with bcd_in=16'h0001 during cycle 5 of the 16'h0500 conversion -> ignored; result 500, only one done.
- rst_n low in cycle 7 of a 16'h8765 conversion -> busy/done/err/binary immediately 0 asynchronously, no done. After release, start with 16'h0010 -> binary=10.
